// File: rtl/instr_addr_stage_pkg.sv
// Shared definitions for the instruction-address stage: datapath width,
// FSM encoding, the address record and a small alignment helper.
package instr_addr_stage_pkg;

  localparam int WORD_LENGTH = 32;

  localparam logic [WORD_LENGTH-1:0] ZERO = '0;

  // Default sequential offset increment (one 32-bit instruction)
  localparam logic [WORD_LENGTH-1:0] IA_INSTR_BYTES = 32'd4;

  // FSM encoding
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Architectural instruction address: status/segment plus offset
  typedef struct packed {
    logic [WORD_LENGTH-1:0] pstate0;
    logic [WORD_LENGTH-1:0] pstate1;
  } ia_addr_t;

  // Instruction offsets must sit on a 4-byte boundary
  function automatic logic offset_aligned(input logic [WORD_LENGTH-1:0] offset);
    return (offset[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_addr_stage_if.sv
// Bus between the IA stage and its neighbours: stall/redirect requests in,
// fetch address and phase out.
interface instr_addr_stage_if;
  import instr_addr_stage_pkg::*;

  logic                   stallIn;
  logic                   brValid;
  logic [WORD_LENGTH-1:0] brPstate0;
  logic [WORD_LENGTH-1:0] brPstate1;
  logic                   trapValid;
  logic [WORD_LENGTH-1:0] trapPstate0;
  logic [WORD_LENGTH-1:0] trapPstate1;
  logic [WORD_LENGTH-1:0] iaFdPstate0;
  logic [WORD_LENGTH-1:0] iaFdPstate1;
  logic                   iaFdValid;
  logic                   iaHalfCycle;
  logic                   iaAlignTrap;

  // Requesting side (hazard unit, branch unit, trap logic, fetch/decode)
  modport master (
    output stallIn, brValid, brPstate0, brPstate1,
           trapValid, trapPstate0, trapPstate1,
    input  iaFdPstate0, iaFdPstate1, iaFdValid, iaHalfCycle, iaAlignTrap
  );

  // The IA stage itself
  modport slave (
    input  stallIn, brValid, brPstate0, brPstate1,
           trapValid, trapPstate0, trapPstate1,
    output iaFdPstate0, iaFdPstate1, iaFdValid, iaHalfCycle, iaAlignTrap
  );

endinterface

// File: rtl/instr_addr_stage_redirect_latch.sv
// Pending-redirect holder: captures a one-clock request pulse and keeps it
// until the end of the pipeline cycle. A newer request overwrites an older
// one. The effective view merges the live input so a request arriving on
// the consuming edge itself is still seen.
module ia_redirect_latch
  import instr_addr_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_valid,
  input  ia_addr_t req_target,
  input  logic     consume,
  output logic     eff_valid,
  output ia_addr_t eff_target
);

  logic     valid_reg;
  ia_addr_t target_reg;

  // Capture/overwrite on a request; drop the entry when it is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      target_reg <= '0;
    end else if (consume) begin
      valid_reg  <= 1'b0;
    end else if (req_valid) begin
      valid_reg  <= 1'b1;
      target_reg <= req_target;
    end
  end

  // Live request takes precedence over the stored one (it is newer)
  always_comb begin
    eff_valid  = req_valid | valid_reg;
    eff_target = req_valid ? req_target : target_reg;
  end

endmodule

// File: rtl/instr_addr_stage.sv
// Instruction-address stage: holds PSTATE0/PSTATE1 and, at the end of each
// two-clock pipeline cycle, issues the next fetch address (boot, trap,
// branch, hold or sequential).
module instr_addr_stage
  import instr_addr_stage_pkg::*;
#(
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE0 = ZERO,
  parameter logic [WORD_LENGTH-1:0] RESET_PSTATE1 = ZERO,
  parameter logic [WORD_LENGTH-1:0] INSTR_BYTES   = IA_INSTR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  instr_addr_stage_if.slave ia
);

  localparam int REQ_BR   = 0;
  localparam int REQ_TRAP = 1;
  localparam int NUM_REQ  = 2;

  logic                   half_reg;
  logic [1:0]             state_reg,   state_next;
  logic [WORD_LENGTH-1:0] pstate0_reg, pstate0_next;
  logic [WORD_LENGTH-1:0] pstate1_reg, pstate1_next;
  logic                   valid_reg,   valid_next;
  logic                   align_reg,   align_next;

  logic [NUM_REQ-1:0] req_valid;
  ia_addr_t           req_target [NUM_REQ];
  logic [NUM_REQ-1:0] eff_valid;
  ia_addr_t           eff_target [NUM_REQ];

  logic end_cycle;
  logic br_aligned;

  assign end_cycle = half_reg;

  assign req_valid[REQ_BR]           = ia.brValid;
  assign req_target[REQ_BR].pstate0  = ia.brPstate0;
  assign req_target[REQ_BR].pstate1  = ia.brPstate1;
  assign req_valid[REQ_TRAP]         = ia.trapValid;
  assign req_target[REQ_TRAP].pstate0 = ia.trapPstate0;
  assign req_target[REQ_TRAP].pstate1 = ia.trapPstate1;

  // Every end-of-cycle edge retires both pending entries: a trap consumes
  // both, a branch is either applied or rejected, and during boot anything
  // pending is discarded. So the consume strobe is simply the cycle end.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      ia_redirect_latch u_latch (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[gi]),
        .req_target (req_target[gi]),
        .consume    (end_cycle),
        .eff_valid  (eff_valid[gi]),
        .eff_target (eff_target[gi])
      );
    end
  endgenerate

  assign br_aligned = offset_aligned(eff_target[REQ_BR].pstate1);

  // Next-address selection: trap > aligned branch > stall > sequential
  always_comb begin
    state_next   = state_reg;
    pstate0_next = pstate0_reg;
    pstate1_next = pstate1_reg;
    valid_next   = valid_reg;
    align_next   = 1'b0;
    if (end_cycle) begin
      if (state_reg == S_BOOT) begin
        pstate0_next = RESET_PSTATE0;
        pstate1_next = RESET_PSTATE1;
        valid_next   = 1'b1;
        state_next   = S_RUN;
      end else if (eff_valid[REQ_TRAP]) begin
        pstate0_next = eff_target[REQ_TRAP].pstate0;
        pstate1_next = eff_target[REQ_TRAP].pstate1;
        valid_next   = 1'b1;
        state_next   = S_RUN;
      end else if (eff_valid[REQ_BR] && br_aligned) begin
        pstate0_next = eff_target[REQ_BR].pstate0;
        pstate1_next = eff_target[REQ_BR].pstate1;
        valid_next   = 1'b1;
        state_next   = S_RUN;
      end else begin
        // A misaligned branch is dropped and flagged; flow continues as normal
        align_next = eff_valid[REQ_BR];
        if (ia.stallIn) begin
          state_next = S_HOLD;
        end else if (state_reg == S_HOLD) begin
          // Leaving a stall re-issues the held address once
          state_next = S_RUN;
        end else begin
          pstate1_next = pstate1_reg + INSTR_BYTES;
          state_next   = S_RUN;
        end
      end
    end
  end

  // Phase toggle and stage state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_reg    <= 1'b0;
      state_reg   <= S_BOOT;
      pstate0_reg <= ZERO;
      pstate1_reg <= ZERO;
      valid_reg   <= 1'b0;
      align_reg   <= 1'b0;
    end else begin
      half_reg    <= ~half_reg;
      state_reg   <= state_next;
      pstate0_reg <= pstate0_next;
      pstate1_reg <= pstate1_next;
      valid_reg   <= valid_next;
      align_reg   <= align_next;
    end
  end

  assign ia.iaFdPstate0 = pstate0_reg;
  assign ia.iaFdPstate1 = pstate1_reg;
  assign ia.iaFdValid   = valid_reg;
  assign ia.iaHalfCycle = half_reg;
  assign ia.iaAlignTrap = align_reg;

endmodule

// File: tb/tb_instr_addr_stage.sv
// Bench for instr_addr_stage: table of per-pipeline-cycle stimulus with
// expected addresses queued to a scoreboard, plus hand-written boot and
// mid-cycle reset sequences.
module tb_instr_addr_stage;
  import instr_addr_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_addr_stage_if ia ();

  instr_addr_stage #(
    .RESET_PSTATE0 (32'h0000_0000),
    .RESET_PSTATE1 (32'h0000_0000),
    .INSTR_BYTES   (32'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ia  (ia)
  );

  typedef struct packed {
    logic        stall;
    logic        br_v;
    logic        br_half;   // 0: pulse in first clk of the cycle, 1: on the end edge
    logic        br_decoy;  // earlier decoy branch in first clk, real one on the end edge
    logic [31:0] br0;
    logic [31:0] br1;
    logic        tr_v;
    logic        tr_half;
    logic [31:0] tr0;
    logic [31:0] tr1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        exp_align;
  } vec_t;

  typedef struct packed {
    logic [31:0] p0;
    logic [31:0] p1;
    logic        valid;
    logic        align;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic vec_t mkv(input logic stall, input logic br_v, input logic br_half,
                               input logic br_decoy, input logic [31:0] br0,
                               input logic [31:0] br1, input logic tr_v, input logic tr_half,
                               input logic [31:0] tr0, input logic [31:0] tr1,
                               input logic [31:0] exp0, input logic [31:0] exp1,
                               input logic exp_align);
    vec_t v;
    v.stall = stall; v.br_v = br_v; v.br_half = br_half; v.br_decoy = br_decoy;
    v.br0 = br0; v.br1 = br1; v.tr_v = tr_v; v.tr_half = tr_half;
    v.tr0 = tr0; v.tr1 = tr1; v.exp0 = exp0; v.exp1 = exp1; v.exp_align = exp_align;
    return v;
  endfunction

  function automatic vec_t idle(input logic stall, input logic [31:0] e0, input logic [31:0] e1);
    return mkv(stall, 0, 0, 0, 0, 0, 0, 0, 0, 0, e0, e1, 0);
  endfunction

  // One pipeline cycle; entered and left 1 time unit after an end-of-cycle edge
  task automatic run_cycle(input vec_t v, input int idx);
    exp_t e;
    ia.stallIn = v.stall;
    if (v.br_decoy) begin
      ia.brValid = 1'b1; ia.brPstate0 = 32'hDEAD_0000; ia.brPstate1 = 32'h0000_0A00;
    end else if (v.br_v && !v.br_half) begin
      ia.brValid = 1'b1; ia.brPstate0 = v.br0; ia.brPstate1 = v.br1;
    end
    if (v.tr_v && !v.tr_half) begin
      ia.trapValid = 1'b1; ia.trapPstate0 = v.tr0; ia.trapPstate1 = v.tr1;
    end
    e.p0 = v.exp0; e.p1 = v.exp1; e.valid = 1'b1; e.align = v.exp_align;
    sb_q.push_back(e);
    @(posedge clk); #1;
    ia.brValid = 1'b0; ia.trapValid = 1'b0;
    check($sformatf("v%0d mid half", idx), 32'(ia.iaHalfCycle), 32'd1);
    check($sformatf("v%0d mid align", idx), 32'(ia.iaAlignTrap), 32'd0);
    if (v.br_decoy || (v.br_v && v.br_half)) begin
      ia.brValid = 1'b1; ia.brPstate0 = v.br0; ia.brPstate1 = v.br1;
    end
    if (v.tr_v && v.tr_half) begin
      ia.trapValid = 1'b1; ia.trapPstate0 = v.tr0; ia.trapPstate1 = v.tr1;
    end
    @(posedge clk); #1;
    ia.brValid = 1'b0; ia.trapValid = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("v%0d pstate0", idx), ia.iaFdPstate0, e.p0);
    check($sformatf("v%0d pstate1", idx), ia.iaFdPstate1, e.p1);
    check($sformatf("v%0d valid", idx), 32'(ia.iaFdValid), 32'(e.valid));
    check($sformatf("v%0d align", idx), 32'(ia.iaAlignTrap), 32'(e.align));
    check($sformatf("v%0d end half", idx), 32'(ia.iaHalfCycle), 32'd0);
    $display("cycle v%0d: stall=%0b br=%0b trap=%0b -> %h/%h valid=%0b align=%0b",
             idx, v.stall, v.br_v, v.tr_v, ia.iaFdPstate0, ia.iaFdPstate1,
             ia.iaFdValid, ia.iaAlignTrap);
  endtask

  // Releases reset just after a clock edge and checks the boot cycle
  task automatic boot_cycle(input string tag);
    rst = 1'b0;
    @(posedge clk); #1;
    check({tag, " mid valid"}, 32'(ia.iaFdValid), 32'd0);
    check({tag, " mid pstate1"}, ia.iaFdPstate1, 32'h0);
    @(posedge clk); #1;
    check({tag, " boot pstate0"}, ia.iaFdPstate0, 32'h0);
    check({tag, " boot pstate1"}, ia.iaFdPstate1, 32'h0);
    check({tag, " boot valid"}, 32'(ia.iaFdValid), 32'd1);
    $display("%s: boot -> %h/%h valid=%0b", tag, ia.iaFdPstate0, ia.iaFdPstate1, ia.iaFdValid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    ia.stallIn = 0; ia.brValid = 0; ia.brPstate0 = 0; ia.brPstate1 = 0;
    ia.trapValid = 0; ia.trapPstate0 = 0; ia.trapPstate1 = 0;

    // Sequential run, stall, branch, trap-vs-branch, misalignment, overwrite, wrap
    vecs.push_back(idle(0, 32'h0, 32'h4));
    vecs.push_back(idle(0, 32'h0, 32'h8));
    vecs.push_back(idle(0, 32'h0, 32'hC));
    vecs.push_back(idle(0, 32'h0, 32'h10));
    vecs.push_back(idle(1, 32'h0, 32'h10));
    vecs.push_back(idle(1, 32'h0, 32'h10));
    vecs.push_back(idle(1, 32'h0, 32'h10));
    vecs.push_back(idle(0, 32'h0, 32'h10));
    vecs.push_back(idle(0, 32'h0, 32'h14));
    vecs.push_back(mkv(0, 1, 0, 0, 32'h0001_0005, 32'h0000_0200, 0, 0, 0, 0,
                       32'h0001_0005, 32'h0000_0200, 0));
    vecs.push_back(idle(0, 32'h0001_0005, 32'h0000_0204));
    vecs.push_back(mkv(1, 1, 0, 0, 32'h0000_0002, 32'h0000_0300, 1, 0,
                       32'h0000_0003, 32'h0000_1000, 32'h3, 32'h1000, 0));
    vecs.push_back(idle(1, 32'h3, 32'h1000));
    vecs.push_back(idle(0, 32'h3, 32'h1000));
    vecs.push_back(idle(0, 32'h3, 32'h1004));
    vecs.push_back(mkv(0, 1, 1, 0, 32'h0000_0007, 32'h0000_0202, 0, 0, 0, 0,
                       32'h3, 32'h1008, 1));
    vecs.push_back(idle(0, 32'h3, 32'h100C));
    vecs.push_back(mkv(0, 1, 1, 1, 32'h0000_0009, 32'h0000_0800, 0, 0, 0, 0,
                       32'h9, 32'h800, 0));
    vecs.push_back(mkv(1, 1, 1, 0, 32'h0000_0004, 32'h0000_0700, 0, 0, 0, 0,
                       32'h4, 32'h700, 0));
    vecs.push_back(idle(1, 32'h4, 32'h700));
    vecs.push_back(idle(0, 32'h4, 32'h700));
    vecs.push_back(idle(0, 32'h4, 32'h704));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0010, 32'hFFFF_FFF8,
                       32'h10, 32'hFFFF_FFF8, 0));
    vecs.push_back(idle(0, 32'h10, 32'hFFFF_FFFC));
    vecs.push_back(idle(0, 32'h10, 32'h0));

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset pstate0", ia.iaFdPstate0, 32'h0);
    check("reset pstate1", ia.iaFdPstate1, 32'h0);
    check("reset valid", 32'(ia.iaFdValid), 32'd0);
    check("reset align", 32'(ia.iaAlignTrap), 32'd0);
    check("reset half", 32'(ia.iaHalfCycle), 32'd0);

    boot_cycle("boot1");

    foreach (vecs[i]) run_cycle(vecs[i], i);

    // Mid-cycle reset with a captured (pending) branch: it must be discarded
    ia.brValid = 1'b1; ia.brPstate0 = 32'h0000_0005; ia.brPstate1 = 32'h0000_0600;
    @(posedge clk); #1;
    ia.brValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst pstate0", ia.iaFdPstate0, 32'h0);
    check("midrst pstate1", ia.iaFdPstate1, 32'h0);
    check("midrst valid", 32'(ia.iaFdValid), 32'd0);
    check("midrst half", 32'(ia.iaHalfCycle), 32'd0);
    $display("midrst: outputs %h/%h valid=%0b", ia.iaFdPstate0, ia.iaFdPstate1, ia.iaFdValid);
    @(posedge clk); #1;
    boot_cycle("boot2");
    run_cycle(idle(0, 32'h0, 32'h4), 100);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
